// File: rtl/text_fetch.sv
// Text-mode fetch stage: for every 8-pixel cell it reads the character code, then the
// glyph row, and hands the pixel byte to the pixel generator ahead of its pix_load.
module text_fetch #(
  parameter int unsigned COLS       = 100,
  parameter int unsigned ROWS       = 37,
  parameter logic [7:0]  BLANK_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pix_load,
  output logic [11:0] ch_addr,
  output logic        ch_rd,
  input  logic [7:0]  ch_data,
  output logic [11:0] font_addr,
  output logic        font_rd,
  input  logic [7:0]  font_data,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  output logic        underrun
);

  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]  ROWS_W   = 6'(ROWS);
  localparam logic [11:0] COLS_W   = 12'(COLS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH   = 3'd1,
    CHD  = 3'd2,
    FN   = 3'd3,
    FND  = 3'd4,
    HOLD = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [3:0]  glyph_q, glyph_d;
  logic [5:0]  trow_q, trow_d;
  logic [11:0] line_base_q, line_base_d;
  logic        first_line_q, first_line_d;
  logic [7:0]  ch_code_q, ch_code_d;
  logic [7:0]  pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic        underrun_q, underrun_d;
  logic        ch_rd_q, ch_rd_d;
  logic [11:0] ch_addr_q, ch_addr_d;
  logic        font_rd_q, font_rd_d;
  logic [11:0] font_addr_q, font_addr_d;

  // Next-state: frame/line control, fetch sequencing and the registered RAM strobes.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    glyph_d      = glyph_q;
    trow_d       = trow_q;
    line_base_d  = line_base_q;
    first_line_d = first_line_q;
    ch_code_d    = ch_code_q;
    pix_data_d   = pix_data_q;
    pix_valid_d  = pix_valid_q;
    underrun_d   = underrun_q;
    ch_rd_d      = 1'b0;
    ch_addr_d    = ch_addr_q;
    font_rd_d    = 1'b0;
    font_addr_d  = font_addr_q;

    // frame_start is applied first so a coincident line_start counts as the first line
    if (frame_start) begin
      glyph_d      = 4'd0;
      trow_d       = 6'd0;
      line_base_d  = 12'd0;
      first_line_d = 1'b1;
      underrun_d   = 1'b0;
      pix_valid_d  = 1'b0;
      state_d      = IDLE;
    end else begin
      first_line_d = first_line_q;
    end

    if (line_start) begin
      if (first_line_d) begin
        first_line_d = 1'b0;
      end else if (glyph_d == 4'd15) begin
        glyph_d     = 4'd0;
        trow_d      = trow_d + 6'd1;
        line_base_d = line_base_d + COLS_W;
      end else begin
        glyph_d = glyph_d + 4'd1;
      end
      col_d       = 7'd0;
      pix_valid_d = 1'b0;
      state_d     = CH;
    end else if (!frame_start) begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        CH: begin
          if (trow_q >= ROWS_W) begin
            pix_data_d  = BLANK_BYTE;
            pix_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = CHD;
          end
        end
        CHD: begin
          ch_code_d = ch_data;
          state_d   = FN;
        end
        FN: begin
          state_d = FND;
        end
        FND: begin
          pix_data_d  = font_data;
          pix_valid_d = 1'b1;
          state_d     = HOLD;
        end
        HOLD: begin
          if (pix_load && pix_valid_q) begin
            pix_valid_d = 1'b0;
            if (col_q < LAST_COL) begin
              col_d   = col_q + 7'd1;
              state_d = CH;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (pix_load && !pix_valid_q) begin
        underrun_d = 1'b1;
      end else begin
        underrun_d = underrun_q;
      end
    end else begin
      state_d = IDLE;
    end

    // Strobes are registered from the next state so they line up with CH / FN exactly.
    if (state_d == CH) begin
      ch_rd_d   = (trow_d < ROWS_W);
      ch_addr_d = line_base_d + {5'd0, col_d};
    end else begin
      ch_rd_d = 1'b0;
    end

    if (state_d == FN) begin
      font_rd_d   = 1'b1;
      font_addr_d = {ch_code_d, glyph_d};
    end else begin
      font_rd_d = 1'b0;
    end
  end

  // State, counters and output registers; async reset clears every output at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      col_q        <= 7'd0;
      glyph_q      <= 4'd0;
      trow_q       <= 6'd0;
      line_base_q  <= 12'd0;
      first_line_q <= 1'b1;
      ch_code_q    <= 8'd0;
      pix_data_q   <= 8'd0;
      pix_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
      ch_rd_q      <= 1'b0;
      ch_addr_q    <= 12'd0;
      font_rd_q    <= 1'b0;
      font_addr_q  <= 12'd0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      glyph_q      <= glyph_d;
      trow_q       <= trow_d;
      line_base_q  <= line_base_d;
      first_line_q <= first_line_d;
      ch_code_q    <= ch_code_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      underrun_q   <= underrun_d;
      ch_rd_q      <= ch_rd_d;
      ch_addr_q    <= ch_addr_d;
      font_rd_q    <= font_rd_d;
      font_addr_q  <= font_addr_d;
    end
  end

  assign ch_addr   = ch_addr_q;
  assign ch_rd     = ch_rd_q;
  assign font_addr = font_addr_q;
  assign font_rd   = font_rd_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_text_fetch.sv
// Self-checking bench for text_fetch: RAM models, a line/cell reference model and
// scenario tasks covering reset, row stepping, blank lines, underrun and line abort.
module tb_text_fetch;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        pix_load = 1'b0;
  logic [11:0] ch_addr, font_addr;
  logic        ch_rd, font_rd, pix_valid, underrun;
  logic [7:0]  ch_data = 8'h00;
  logic [7:0]  font_data = 8'h00;
  logic [7:0]  pix_data;

  logic [7:0]  char_mem [0:4095];
  logic [7:0]  font_mem [0:4095];
  logic [11:0] ch_log[$];
  logic [11:0] font_log[$];

  int   tests = 0;
  int   fails = 0;
  int   next_line = 0;
  bit   underrun_exp = 1'b0;
  logic [7:0] first_pix;

  always #5 clk = ~clk;

  text_fetch dut (
    .clk(clk), .nrst(nrst), .frame_start(frame_start), .line_start(line_start),
    .pix_load(pix_load), .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_data(ch_data),
    .font_addr(font_addr), .font_rd(font_rd), .font_data(font_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun)
  );

  // synchronous-read RAMs: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (ch_rd) ch_data <= char_mem[ch_addr];
    if (font_rd) font_data <= font_mem[font_addr];
  end

  always @(negedge clk) begin
    if (nrst && ch_rd) ch_log.push_back(ch_addr);
    if (nrst && font_rd) font_log.push_back(font_addr);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: line index within the frame and cell column.
  function automatic logic [11:0] exp_ch_addr(int line, int c);
    return 12'((line / 16) * 100 + c);
  endfunction

  function automatic logic [11:0] exp_font_addr(int line, int c);
    return {char_mem[exp_ch_addr(line, c)], 4'(line % 16)};
  endfunction

  function automatic logic [7:0] exp_pix(int line, int c);
    if ((line / 16) >= 37) return 8'h00;
    else return font_mem[exp_font_addr(line, c)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_spec_mem();
    for (int a = 0; a < 4096; a++) begin
      char_mem[a] = a[7:0];
      font_mem[a] = a[11:4] ^ {4'h0, a[3:0]};
    end
  endtask

  task automatic fill_rand_mem();
    for (int a = 0; a < 4096; a++) begin
      char_mem[a] = 8'($urandom);
      font_mem[a] = 8'($urandom);
    end
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    next_line = 0;
    underrun_exp = 1'b0;
  endtask

  task automatic fast_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (5) tick();
    next_line++;
  endtask

  // Starts the next line and delivers n_cells cells; n_cells<100 leaves the
  // following fetch in its CHD cycle so the next line_start aborts it.
  task automatic run_line(input int n_cells, input bit early, input int jit_max);
    int  line;
    bit  blank;
    int  exp_ch_n;
    logic exp_v;
    line = next_line;
    next_line++;
    blank = (line / 16) >= 37;
    ch_log.delete();
    font_log.delete();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (early && k == 2) pix_load = 1'b1;
      tick();
      pix_load = 1'b0;
      @(negedge clk);
      exp_v = (blank || k >= 4) ? 1'b1 : 1'b0;
      tests++;
      if (pix_valid !== exp_v) begin
        fails++;
        $display("FAIL latency line %0d clk %0d: pix_valid=%b required %b", line, k, pix_valid, exp_v);
      end
      if (early && k == 2) begin
        underrun_exp = 1'b1;
        tests++;
        if (underrun !== 1'b1) begin
          fails++;
          $display("FAIL early_load line %0d: underrun=%b required 1", line, underrun);
        end
      end
    end
    for (int c = 0; c < n_cells; c++) begin
      if (c == 0) first_pix = pix_data;
      tests++;
      if (pix_valid !== 1'b1 || pix_data !== exp_pix(line, c)) begin
        fails++;
        $display("FAIL cell line %0d col %0d: valid=%b data=%h required valid=1 data=%h",
                 line, c, pix_valid, pix_data, exp_pix(line, c));
      end
      pix_load = 1'b1;
      tick();
      pix_load = 1'b0;
      if (c < n_cells - 1) begin
        repeat (7 + $urandom_range(jit_max, 0)) @(posedge clk);
        @(negedge clk);
      end
    end
    if (n_cells == 100) begin
      @(negedge clk);
      tests++;
      if (pix_valid !== 1'b0) begin
        fails++;
        $display("FAIL line_end line %0d: pix_valid=%b required 0", line, pix_valid);
      end
      tick();
    end else begin
      tick();
    end
    exp_ch_n = (n_cells == 100) ? 100 : n_cells + 1;
    tests++;
    if (blank) begin
      if (ch_log.size() != 0 || font_log.size() != 0) begin
        fails++;
        $display("FAIL blank_reads line %0d: ch_rd=%0d font_rd=%0d pulses, required 0/0",
                 line, ch_log.size(), font_log.size());
      end
    end else if (ch_log.size() != exp_ch_n || font_log.size() != n_cells) begin
      fails++;
      $display("FAIL read_count line %0d: ch_rd=%0d font_rd=%0d pulses, required %0d/%0d",
               line, ch_log.size(), font_log.size(), exp_ch_n, n_cells);
    end else begin
      for (int i = 0; i < n_cells; i++) begin
        tests++;
        if (ch_log[i] !== exp_ch_addr(line, i) || font_log[i] !== exp_font_addr(line, i)) begin
          fails++;
          $display("FAIL addr line %0d col %0d: ch_addr=%h font_addr=%h required %h/%h",
                   line, i, ch_log[i], font_log[i], exp_ch_addr(line, i), exp_font_addr(line, i));
        end
      end
    end
    tests++;
    if (underrun !== underrun_exp) begin
      fails++;
      $display("FAIL underrun_hold line %0d: underrun=%b required %b", line, underrun, underrun_exp);
    end
  endtask

  task automatic test_reset();
    int idx;
    #1 nrst = 1'b0;
    #2;
    tests++;
    if ({ch_rd, font_rd, pix_valid, underrun} !== 4'b0000 || pix_data !== 8'h00 ||
        ch_addr !== 12'h000 || font_addr !== 12'h000) begin
      fails++;
      $display("FAIL reset_init: rd=%b%b valid=%b ur=%b data=%h ca=%h fa=%h required all 0",
               ch_rd, font_rd, pix_valid, underrun, pix_data, ch_addr, font_addr);
    end
    @(posedge clk);
    #1 nrst = 1'b1;
    tick();
    fill_rand_mem();
    idx = {char_mem[0], 4'h0};
    font_mem[idx] = 8'hA5;
    do_frame();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    pix_load = 1'b1;
    tick();
    pix_load = 1'b0;
    repeat (3) tick();
    pix_load = 1'b1;
    tick();
    pix_load = 1'b0;
    repeat (2) tick();
    #1;
    tests++;
    if (font_rd !== 1'b1 || pix_data !== 8'hA5 || underrun !== 1'b1 || pix_valid !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_fn: font_rd=%b data=%h ur=%b valid=%b required 1/a5/1/0",
               font_rd, pix_data, underrun, pix_valid);
    end
    #1 nrst = 1'b0;
    #1;
    tests++;
    if ({ch_rd, font_rd, pix_valid, underrun} !== 4'b0000 || pix_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_async: rd=%b%b valid=%b ur=%b data=%h required all 0",
               ch_rd, font_rd, pix_valid, underrun, pix_data);
    end
    @(posedge clk);
    #1 nrst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    fill_spec_mem();
    do_frame();
    run_line(100, 1'b0, 0);
    tests++;
    if (ch_log.size() < 3 || ch_log[2] !== 12'd2 || font_log[2] !== 12'h020 || first_pix !== 8'h00) begin
      fails++;
      $display("FAIL basic_first: ch_addr[2]=%h font_addr[2]=%h pix0=%h required 002/020/00",
               (ch_log.size() > 2) ? ch_log[2] : 12'hfff, (font_log.size() > 2) ? font_log[2] : 12'hfff, first_pix);
    end
  endtask

  task automatic test_rows();
    repeat (15) fast_line();
    run_line(100, 1'b0, 0);
    tests++;
    if (ch_log.size() == 0 || ch_log[0] !== 12'd100 || font_log[0] !== 12'h640 || first_pix !== 8'h64) begin
      fails++;
      $display("FAIL row1_glyph0: pix0=%h required ch_addr 064 font_addr 640 pix 64", first_pix);
    end
    run_line(100, 1'b0, 0);
    tests++;
    if (font_log.size() == 0 || font_log[0] !== 12'h641 || first_pix !== 8'h65) begin
      fails++;
      $display("FAIL row1_glyph1: pix0=%h required font_addr 641 pix 65", first_pix);
    end
  endtask

  task automatic test_blank();
    while (next_line < 592) fast_line();
    run_line(100, 1'b0, 0);
  endtask

  task automatic test_underrun();
    fill_rand_mem();
    do_frame();
    run_line(100, 1'b1, 2);
    run_line(100, 1'b0, 3);
    do_frame();
    tests++;
    if (underrun !== 1'b0) begin
      fails++;
      $display("FAIL underrun_clear: underrun=%b required 0", underrun);
    end
  endtask

  task automatic test_abort();
    fill_rand_mem();
    do_frame();
    run_line(50, 1'b0, 2);
    run_line(100, 1'b0, 0);
    tests++;
    if (ch_log.size() == 0 || ch_log[0] !== 12'd0) begin
      fails++;
      $display("FAIL abort_restart: first ch_addr after abort not 000");
    end
  endtask

  task automatic test_random_lines();
    fill_rand_mem();
    do_frame();
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(20, 1)) fast_line();
      run_line(100, 1'b0, 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rows();
    test_blank();
    test_underrun();
    test_abort();
    test_random_lines();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
